// File: rtl/matmul_engine.sv
// Matrix-multiply engine: holds A (row x inner) and B (inner x column), computes
// R = A x B one element at a time on a single 8-bit wrapping MAC and streams R out.
module matmul_engine #(
  parameter int unsigned row    = 2,
  parameter int unsigned column = 2,
  parameter int unsigned inner  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        a_write,
  input  logic [31:0] a_addr,
  input  logic [7:0]  a_value,
  input  logic        b_write,
  input  logic [31:0] b_addr,
  input  logic [7:0]  b_value,
  output logic        busy,
  output logic        done,
  output logic        write_R,
  output logic [31:0] write_address_R,
  output logic [7:0]  write_value_R
);

  localparam int unsigned A_SIZE = row * inner;
  localparam int unsigned B_SIZE = inner * column;
  localparam int unsigned AW = (A_SIZE > 1) ? $clog2(A_SIZE) : 1;
  localparam int unsigned BW = (B_SIZE > 1) ? $clog2(B_SIZE) : 1;
  localparam int unsigned IW = (row > 1) ? $clog2(row) : 1;
  localparam int unsigned JW = (column > 1) ? $clog2(column) : 1;
  localparam int unsigned KW = (inner > 1) ? $clog2(inner) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    acc_q, acc_d;
  logic          write_q, write_d;
  logic          done_q, done_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [7:0]    wval_q, wval_d;

  logic [7:0]    a_q [A_SIZE];
  logic [7:0]    b_q [B_SIZE];

  logic [7:0]    a_elem_c, b_elem_c, acc_sum_c;
  logic [15:0]   prod_c;
  logic          a_we_c, b_we_c;

  // Operand fetch and wrapping multiply-accumulate for the current (i,j,k)
  assign a_elem_c  = a_q[AW'(32'(i_q) * inner + 32'(k_q))];
  assign b_elem_c  = b_q[BW'(32'(k_q) * column + 32'(j_q))];
  assign prod_c    = 16'(a_elem_c) * 16'(b_elem_c);
  assign acc_sum_c = 8'(16'(acc_q) + prod_c);

  assign a_we_c = (state_q == IDLE) && a_write && (a_addr < A_SIZE);
  assign b_we_c = (state_q == IDLE) && b_write && (b_addr < B_SIZE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < A_SIZE; n++) a_q[AW'(n)] <= 8'd0;
    end else if (a_we_c) begin
      a_q[a_addr[AW-1:0]] <= a_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < B_SIZE; n++) b_q[BW'(n)] <= 8'd0;
    end else if (b_we_c) begin
      b_q[b_addr[BW-1:0]] <= b_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= 8'd0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      waddr_q <= 32'd0;
      wval_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      write_q <= write_d;
      done_q  <= done_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
    end
  end

  // Strobe and done registers are set on the edge entering WRITE / DONE
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = 8'd0;
        end
      end
      MAC: begin
        acc_d = acc_sum_c;
        if (k_q == KW'(inner - 1)) begin
          state_d = WRITE;
          write_d = 1'b1;
          waddr_d = 32'(i_q) * column + 32'(j_q);
          wval_d  = acc_sum_c;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WRITE: begin
        acc_d   = 8'd0;
        k_d     = '0;
        state_d = MAC;
        if (j_q == JW'(column - 1)) begin
          j_d = '0;
          if (i_q == IW'(row - 1)) begin
            i_d     = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign write_R         = write_q;
  assign write_address_R = waddr_q;
  assign write_value_R   = wval_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: 2x2 instance plus a 3x1 (inner 4) instance,
// checked cycle by cycle against a plain-arithmetic matrix product model.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, a_write, b_write;
  logic [31:0] a_addr, b_addr;
  logic [7:0]  a_value, b_value;
  logic        busy, done, write_R;
  logic [31:0] write_address_R;
  logic [7:0]  write_value_R;

  logic        s_start, s_a_write, s_b_write;
  logic [31:0] s_a_addr, s_b_addr;
  logic [7:0]  s_a_value, s_b_value;
  logic        s_busy, s_done, s_write_R;
  logic [31:0] s_write_address_R;
  logic [7:0]  s_write_value_R;

  matmul_engine #(.row(2), .column(2), .inner(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a_write(a_write), .a_addr(a_addr), .a_value(a_value),
    .b_write(b_write), .b_addr(b_addr), .b_value(b_value),
    .busy(busy), .done(done), .write_R(write_R),
    .write_address_R(write_address_R), .write_value_R(write_value_R)
  );

  matmul_engine #(.row(3), .column(1), .inner(4)) u_sweep (
    .clk(clk), .rst(rst), .start(s_start),
    .a_write(s_a_write), .a_addr(s_a_addr), .a_value(s_a_value),
    .b_write(s_b_write), .b_addr(s_b_addr), .b_value(s_b_value),
    .busy(s_busy), .done(s_done), .write_R(s_write_R),
    .write_address_R(s_write_address_R), .write_value_R(s_write_value_R)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ma[16], mb[16], sa[16], sb[16];
  int last_addr, last_val;

  // R[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 256 once at the end
  function automatic int ref_elem(input int a[16], input int b[16],
                                  input int i, input int j, input int cc, input int kk);
    int s = 0;
    for (int k = 0; k < kk; k++) s += a[i*kk + k] * b[k*cc + j];
    return s % 256;
  endfunction

  task automatic wr_ab(input int ai, input int av, input int bi, input int bv);
    a_write = (ai >= 0); a_addr = 32'(ai < 0 ? 0 : ai); a_value = 8'(av);
    b_write = (bi >= 0); b_addr = 32'(bi < 0 ? 0 : bi); b_value = 8'(bv);
    if (ai >= 0 && ai < 4) ma[ai] = av;
    if (bi >= 0 && bi < 4) mb[bi] = bv;
    @(negedge clk);
    a_write = 1'b0; b_write = 1'b0;
  endtask

  // One 2x2 run starting on the next edge; inj_c > 0 injects an A write and start while busy
  task automatic run_2x2(input string tag, input int inj_c);
    bit ew, ed, eb;
    int ea, ev;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; a_write = 1'b0; b_write = 1'b0; end
      ew = (c % 3 == 0) && (c / 3 >= 1) && (c / 3 <= 4);
      ed = (c == 13);
      eb = (c <= 13);
      if (ew) begin
        last_addr = c / 3 - 1;
        last_val  = ref_elem(ma, mb, last_addr / 2, last_addr % 2, 2, 2);
      end
      ea = last_addr; ev = last_val;
      n_cmp += 5;
      if (write_R !== ew) begin n_err++; $display("FAIL %s c%0d write_R got %0b exp %0b", tag, c, write_R, ew); end
      if (done !== ed) begin n_err++; $display("FAIL %s c%0d done got %0b exp %0b", tag, c, done, ed); end
      if (busy !== eb) begin n_err++; $display("FAIL %s c%0d busy got %0b exp %0b", tag, c, busy, eb); end
      if (write_address_R !== 32'(ea)) begin n_err++; $display("FAIL %s c%0d addr got %0d exp %0d", tag, c, write_address_R, ea); end
      if (write_value_R !== 8'(ev)) begin n_err++; $display("FAIL %s c%0d value got %0d exp %0d", tag, c, write_value_R, ev); end
      if (inj_c > 0 && c == inj_c) begin
        a_write = 1'b1; a_addr = 32'd0; a_value = 8'd9; start = 1'b1;
      end
      if (inj_c > 0 && c == inj_c + 1) begin a_write = 1'b0; start = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b0 || s_busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %0b/%0b exp 0", busy, s_busy); end
    if (done !== 1'b0 || s_done !== 1'b0) begin n_err++; $display("FAIL reset done got %0b/%0b exp 0", done, s_done); end
    if (write_R !== 1'b0 || s_write_R !== 1'b0) begin n_err++; $display("FAIL reset write_R got %0b/%0b exp 0", write_R, s_write_R); end
    if (write_address_R !== 32'd0) begin n_err++; $display("FAIL reset addr got %0d exp 0", write_address_R); end
    if (write_value_R !== 8'd0) begin n_err++; $display("FAIL reset value got %0d exp 0", write_value_R); end
    rst = 1'b0;
    last_addr = 0; last_val = 0;
  endtask

  task automatic test_basic();
    wr_ab(0, 1, 0, 5); wr_ab(1, 2, 1, 6); wr_ab(2, 3, 2, 7); wr_ab(3, 4, 3, 8);
    n_cmp++;
    if (ref_elem(ma, mb, 1, 1, 2, 2) !== 50) begin n_err++; $display("FAIL model_r11 got %0d exp 50", ref_elem(ma, mb, 1, 1, 2, 2)); end
    run_2x2("basic", 0);
  endtask

  task automatic test_overflow();
    for (int n = 0; n < 4; n++) wr_ab(n, 16, n, 16);
    run_2x2("ovf16", 0);
    wr_ab(0, 255, 0, 1); wr_ab(1, 1, 1, 0); wr_ab(2, 0, 2, 1); wr_ab(3, 0, 3, 0);
    run_2x2("ovf255", 0);
  endtask

  task automatic test_ignored();
    wr_ab(0, 1, 0, 5); wr_ab(1, 2, 1, 6); wr_ab(2, 3, 2, 7); wr_ab(3, 4, 3, 8);
    run_2x2("busy_inj", 2);
    wr_ab(7, 99, 5, 77);
    run_2x2("oob_addr", 0);
  endtask

  task automatic test_start_with_write();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    a_write = 1'b1; a_addr = 32'd3; a_value = v; ma[3] = int'(v);
    run_2x2("start_wr", 0);
  endtask

  task automatic test_back_to_back();
    run_2x2("b2b_1", 0);
    run_2x2("b2b_2", 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int n = 0; n < 4; n++) wr_ab(n, int'($urandom_range(0, 255)), n, int'($urandom_range(0, 255)));
      run_2x2("random", 0);
    end
  endtask

  task automatic test_reset_midrun();
    wr_ab(0, 1, 0, 5); wr_ab(1, 2, 1, 6); wr_ab(2, 3, 2, 7); wr_ab(3, 4, 3, 8);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3 || c == 6) begin
        n_cmp++;
        if (write_R !== 1'b1) begin n_err++; $display("FAIL rst_pre c%0d write_R got %0b exp 1", c, write_R); end
      end
    end
    rst = 1'b1;
    #1;
    n_cmp += 4;
    if (write_R !== 1'b0) begin n_err++; $display("FAIL rst_mid write_R got %0b exp 0", write_R); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %0b exp 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid done got %0b exp 0", done); end
    if (write_address_R !== 32'd0) begin n_err++; $display("FAIL rst_mid addr got %0d exp 0", write_address_R); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 16; n++) begin ma[n] = 0; mb[n] = 0; sa[n] = 0; sb[n] = 0; end
    last_addr = 0; last_val = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      n_cmp++;
      if (write_R !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rst_quiet c%0d w/d/b got %0b%0b%0b exp 000", c, write_R, done, busy);
      end
    end
    run_2x2("rst_rerun", 0);
  endtask

  task automatic test_sweep();
    bit ew, ed, eb;
    int la, lv;
    for (int n = 0; n < 12; n++) begin
      s_a_write = 1'b1; s_a_addr = 32'(n); s_a_value = 8'd1; sa[n] = 1;
      s_b_write = (n < 4); s_b_addr = 32'(n); s_b_value = 8'(n + 1);
      if (n < 4) sb[n] = n + 1;
      @(negedge clk);
    end
    s_a_write = 1'b0; s_b_write = 1'b0;
    la = 0; lv = 0;
    s_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) s_start = 1'b0;
      ew = (c % 5 == 0) && (c / 5 >= 1) && (c / 5 <= 3);
      ed = (c == 16);
      eb = (c <= 16);
      if (ew) begin la = c / 5 - 1; lv = ref_elem(sa, sb, la, 0, 1, 4); end
      n_cmp += 5;
      if (s_write_R !== ew) begin n_err++; $display("FAIL sweep c%0d write_R got %0b exp %0b", c, s_write_R, ew); end
      if (s_done !== ed) begin n_err++; $display("FAIL sweep c%0d done got %0b exp %0b", c, s_done, ed); end
      if (s_busy !== eb) begin n_err++; $display("FAIL sweep c%0d busy got %0b exp %0b", c, s_busy, eb); end
      if (s_write_address_R !== 32'(la)) begin n_err++; $display("FAIL sweep c%0d addr got %0d exp %0d", c, s_write_address_R, la); end
      if (s_write_value_R !== 8'(lv)) begin n_err++; $display("FAIL sweep c%0d value got %0d exp %0d", c, s_write_value_R, lv); end
    end
  endtask

  initial begin
    start = 1'b0; a_write = 1'b0; b_write = 1'b0;
    a_addr = 32'd0; b_addr = 32'd0; a_value = 8'd0; b_value = 8'd0;
    s_start = 1'b0; s_a_write = 1'b0; s_b_write = 1'b0;
    s_a_addr = 32'd0; s_b_addr = 32'd0; s_a_value = 8'd0; s_b_value = 8'd0;
    for (int n = 0; n < 16; n++) begin ma[n] = 0; mb[n] = 0; sa[n] = 0; sb[n] = 0; end
    test_reset();
    test_basic();
    test_overflow();
    test_ignored();
    test_start_with_write();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
